bcd_hex_display: RTL
====================

// Module: bcd_hex_display
// PURPOSE
//  Downstream stage of the 20-bit stopwatch counter: converts its binary count to six BCD digits.
//  Conversion is sequential double-dabble, one shift per clock.
//  The result drives six active-low 7-segment displays HEX5..HEX0.
//  Outputs hold the last completed result until the next conversion completes.
// PARAMETERS
//  WIDTH   20      binary input width; one SHIFT cycle per bit
//  DIGITS  6       BCD digits / displays driven
// PORTS
//  Clock     in   1        single clock
//  Reset     in   1        synchronous, active-high
//  Bin       in   WIDTH    binary value to convert (counter Q)
//  Load      in   1        request a conversion of Bin; ignored while Busy
//  Busy      out  1        high in SHIFT and DONE
//  Done      out  1        one-cycle pulse when BCD/HEX update
//  Overflow  out  1        last conversion exceeded 10^DIGITS-1
//  BCD       out  4*DIGITS packed digits, digit0 in [3:0]
//  HEX0..5   out  7 each   segments {g,f,e,d,c,b,a}, 0 = lit
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, Busy=0, Done=0, Overflow=0, BCD=0, counter=0.
//    Reset display: every HEX = 7'h40 ('0'), subject to CONFIGURATION.
//    Reset wins over any in-flight conversion; no Done pulse follows.
//  - IDLE: Load=1 at edge k
//      * capture Bin into shift reg
//      * clear scratch (4*(DIGITS+1) bits; extra digit detects overflow)
//      * counter=0; go to SHIFT
//  - SHIFT: each cycle
//      * add 3 to every scratch digit >=5
//      * shift {scratch,shiftreg} left 1
//      * counter++; after WIDTH shifts (counter==WIDTH-1) go to DONE
//  - DONE: one cycle
//      * top scratch digit !=0 -> BCD=all 9s, Overflow=1
//      * otherwise BCD=scratch[4*DIGITS-1:0], Overflow=0
//      * HEX regs updated together with BCD; Done=1; go to IDLE
//  - Latency: Load at edge k -> Done/BCD/HEX valid after edge k+WIDTH+1 (21 cycles).
//    Back-to-back Loads give one result per WIDTH+2 cycles.
//  - Load while Busy (SHIFT or DONE) is dropped, not queued; Bin is only sampled in IDLE.
//  - Load in the same cycle as Reset is ignored.
//  - Bin may change freely after the capture edge.
//  - All outputs registered; BCD/HEX/Overflow change only on Done or Reset.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined
//    - HEX5 down to HEX1: each zero digit above the most significant non-zero digit shows 7'h7F (blank).
//    - HEX0 always shows its digit; reset shows HEX0=7'h40, others 7'h7F.
//  Undefined: every digit displayed, including leading zeros.
//  BCD and Overflow are identical in both builds.
// STRUCTURE
//  - Package bcd_disp_pkg:
//      * state enum {IDLE, SHIFT, DONE}
//      * SEG_BLANK=7'h7F, SEG_ZERO=7'h40
//      * 16-entry segment constant table (0-9 glyphs, A-F unused -> blank)
//  - Sub-module seg7_decoder: 4-bit digit + blank -> 7-bit active-low; instantiated DIGITS times.
//  - Top holds the FSM, counter, shift/scratch regs and output regs.
// TESTING
//  1. Reset; Bin=0, Load -> Done 21 cycles later; BCD=24'h000000; HEX0..5=7'h40 (macro off).
//  2. Bin=20'd123456, Load -> BCD=24'h123456, HEX5=7'h79, HEX0=7'h02, Overflow=0.
//  3. Bin=20'd999999 -> BCD=24'h999999, Overflow=0.
//     Then Bin=20'hFFFFF -> BCD=24'h999999, Overflow=1.
//  4. Load Bin=20'd5; at cycle 5 of SHIFT, Load Bin=20'd7 -> one Done only; BCD=24'h000005; Busy high 21 cycles.
//  5. Reset at cycle 10 of SHIFT -> next cycle Busy=0, BCD=0, Overflow=0; no Done within 30 cycles.
//  6. Bin=20'd42 with macro -> HEX5..2=7'h7F, HEX1=7'h19, HEX0=7'h24.
//     Same stimulus without macro -> HEX5..2=7'h40.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD conversion / 7-segment display block.
// Segment encoding is {g,f,e,d,c,b,a}. The segments are active low, so a 0 bit lights that segment.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Glyphs for 0-9. Codes A-F never occur in valid BCD, so they show blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, SEG_ZERO
    };

endpackage

// File: rtl/seg7_decoder.sv
// Converts one BCD digit to an active-low 7-segment pattern.
// When the blank input is asserted, every segment is turned off.
module seg7_decoder
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blanking takes priority over the glyph lookup.
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : SEG_TABLE[digit_i];
    end

endmodule

// File: rtl/bcd_hex_display.sv
// Converts the stopwatch's binary count to BCD with a sequential double-dabble (one shift per clock).
// It then drives six active-low 7-segment displays.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on HEX5..HEX1.
// The hex0_o..hex5_o ports assume DIGITS == 6.
module bcd_hex_display
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      bin_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [6:0]            hex0_o,
    output logic [6:0]            hex1_o,
    output logic [6:0]            hex2_o,
    output logic [6:0]            hex3_o,
    output logic [6:0]            hex4_o,
    output logic [6:0]            hex5_o
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(WIDTH);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0][6:0] HEX_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
`else
    localparam logic [DIGITS-1:0][6:0] HEX_RESET = {DIGITS{SEG_ZERO}};
`endif

    state_t                    state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [WIDTH-1:0]          binShift_q, binShift_d;
    logic [SW-1:0]             scratch_q, scratch_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;
    logic [4*DIGITS-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0][6:0]    hex_q, hex_d;

    logic [SW-1:0]             adjusted;
    logic [SW+WIDTH-1:0]       shifted;
    logic                      resultOverflow;
    logic [4*DIGITS-1:0]       resultBcd;
    logic [DIGITS-1:0]         blank;
    logic [DIGITS-1:0][6:0]    segNext;

    // Add-3 correction on every scratch digit >= 5, then shift the whole scratch/binary pair left by one.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted, binShift_q} << 1;
    end

    // The extra top digit being non-zero means the value does not fit, so the result saturates to all nines.
    always_comb begin
        resultOverflow = (scratch_q[SW-1 -: 4] != 4'd0);
        resultBcd      = resultOverflow ? {DIGITS{4'h9}} : scratch_q[4*DIGITS-1:0];
    end

    // A display is blanked only when it and every digit above it are zero; HEX0 always shows its digit.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            blank[i] = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (resultBcd[4*j +: 4] != 4'd0) begin
                    blank[i] = 1'b0;
                end
            end
        end
`endif
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gDecode
            seg7_decoder uDecoder (
                .digit_i (resultBcd[4*g +: 4]),
                .blank_i (blank[g]),
                .seg_o   (segNext[g])
            );
        end
    endgenerate

    // Next-state and datapath logic: capture in IDLE, shift WIDTH times, then publish the result in DONE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        binShift_d = binShift_q;
        scratch_d  = scratch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        hex_d      = hex_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    binShift_d = bin_i;
                    scratch_d  = '0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, binShift_d} = shifted;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = resultBcd;
                overflow_d = resultOverflow;
                hex_d      = segNext;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any in-flight conversion without producing a Done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            binShift_q <= '0;
            scratch_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            hex_q      <= HEX_RESET;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            binShift_q <= binShift_d;
            scratch_q  <= scratch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            hex_q      <= hex_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign bcd_o      = bcd_q;
    assign hex0_o     = hex_q[0];
    assign hex1_o     = hex_q[1];
    assign hex2_o     = hex_q[2];
    assign hex3_o     = hex_q[3];
    assign hex4_o     = hex_q[4];
    assign hex5_o     = hex_q[5];

endmodule
